backprop_sequencer: RTL and testbench

- Sequences the derivative datapath (`different`) over every layer of the network, from the output layer down to layer 0, to run one backward pass.
- Per layer: fetches operands from layer memory and lets the derivative block settle.
- Then forms per-lane gradients and the delta carried back to the next layer, and streams the gradients out through a valid/ready write port.
- Sits between the training controller (start/done) and weight-update storage.

---
 rtl/backprop_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_backprop_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backprop_sequencer.sv
// Backward-pass sequencer: walks layers from N-1 down to 0. For each layer it
// fetches the derivative-block outputs, forms per-lane gradients and the delta
// for the next layer, and streams the gradients out on a valid/ready port.
module backprop_sequencer #(
  parameter int size       = 3,
  parameter int data_size  = 16,
  parameter int frac_bits  = 8,
  parameter int layer_bits = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [layer_bits-1:0]        num_layers,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_req,
  output logic [layer_bits-1:0]        rd_layer,
  input  logic                         rd_ack,
  input  logic [size*data_size-1:0]    diff_cost,
  input  logic [size*data_size-1:0]    diff_start,
  input  logic [size*data_size-1:0]    diff_to_all,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [layer_bits-1:0]        wr_layer,
  output logic [size*data_size-1:0]    wr_grad
);

  localparam int VW = size * data_size;
  localparam int PW = 2 * data_size;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  // Signed fixed-point multiply, rescale by frac_bits, clamp to data_size.
  function automatic logic signed [data_size-1:0] sat_mul_shift(
    input logic signed [data_size-1:0] a,
    input logic signed [data_size-1:0] b
  );
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shr;
    prod = PW'(a) * PW'(b);
    shr  = prod >>> frac_bits;
    if ((shr[PW-1:data_size-1] == '0) || (shr[PW-1:data_size-1] == '1)) begin
      return shr[data_size-1:0];
    end else if (shr[PW-1]) begin
      return {1'b1, {(data_size-1){1'b0}}};
    end else begin
      return {1'b0, {(data_size-1){1'b1}}};
    end
  endfunction

  state_t                 state_q, state_d;
  logic [layer_bits-1:0]  n_q, n_d;
  logic [layer_bits-1:0]  layer_q, layer_d;
  logic [layer_bits-1:0]  wr_layer_q, wr_layer_d;
  logic [VW-1:0]          grad_q, grad_d;
  logic [VW-1:0]          delta_q, delta_d;
  logic [VW-1:0]          cost_q, cost_d;
  logic [VW-1:0]          dstart_q, dstart_d;
  logic [VW-1:0]          dall_q, dall_d;

  logic [layer_bits-1:0]  n_start;
  logic                   is_out_layer;
  logic signed [data_size-1:0] dl;
  logic [VW-1:0]          calc_grad;
  logic [VW-1:0]          calc_delta;

  // A layer count of zero runs a single layer.
  assign n_start = (num_layers == '0) ? layer_bits'(1) : num_layers;

  // Per-lane gradient and next delta from the captured operands.
  always_comb begin
    is_out_layer = (layer_q == (n_q - layer_bits'(1)));
    calc_grad    = '0;
    calc_delta   = '0;
    dl           = '0;
    for (int i = 0; i < size; i++) begin
      dl = is_out_layer ? cost_q[i*data_size +: data_size]
                        : delta_q[i*data_size +: data_size];
      calc_grad[i*data_size +: data_size]  =
        sat_mul_shift(dl, dstart_q[i*data_size +: data_size]);
      calc_delta[i*data_size +: data_size] =
        sat_mul_shift(dl, dall_q[i*data_size +: data_size]);
    end
  end

  // Next-state, register updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    layer_d    = layer_q;
    wr_layer_d = wr_layer_q;
    grad_d     = grad_q;
    delta_d    = delta_q;
    cost_d     = cost_q;
    dstart_d   = dstart_q;
    dall_d     = dall_q;
    busy       = 1'b0;
    done       = 1'b0;
    rd_req     = 1'b0;
    wr_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_start;
          layer_d = n_start - layer_bits'(1);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_ack) begin
          cost_d   = diff_cost;
          dstart_d = diff_start;
          dall_d   = diff_to_all;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        busy       = 1'b1;
        grad_d     = calc_grad;
        delta_d    = calc_delta;
        wr_layer_d = layer_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) begin
          if (layer_q == '0) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q - layer_bits'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      layer_q    <= '0;
      wr_layer_q <= '0;
      grad_q     <= '0;
      delta_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      layer_q    <= layer_d;
      wr_layer_q <= wr_layer_d;
      grad_q     <= grad_d;
      delta_q    <= delta_d;
    end
  end

  // Operand capture; always loaded in FETCH before CALC reads it.
  always_ff @(posedge clk) begin
    cost_q   <= cost_d;
    dstart_q <= dstart_d;
    dall_q   <= dall_d;
  end

  assign rd_layer = layer_q;
  assign wr_layer = wr_layer_q;
  assign wr_grad  = grad_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Randomized bench for backprop_sequencer with a spec-level reference model.
module tb_backprop_sequencer;
  localparam int SZ = 3;
  localparam int DW = 16;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n, start, rd_ack, wr_ready;
  logic [LB-1:0] num_layers, rd_layer, wr_layer;
  logic busy, done, rd_req, wr_valid;
  logic [SZ*DW-1:0] diff_cost, diff_start, diff_to_all, wr_grad;

  backprop_sequencer #(.size(SZ), .data_size(DW), .frac_bits(8), .layer_bits(LB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_layer(rd_layer),
    .rd_ack(rd_ack), .diff_cost(diff_cost), .diff_start(diff_start),
    .diff_to_all(diff_to_all), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_layer(wr_layer), .wr_grad(wr_grad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int layer; logic [SZ*DW-1:0] grad; } wr_t;
  wr_t expq[$];
  wr_t wr_log[$];
  wr_t e;

  logic [DW-1:0] cost_a [16][SZ];
  logic [DW-1:0] start_a[16][SZ];
  logic [DW-1:0] toall_a[16][SZ];

  int  cfg_rd = 0, cfg_wr = 0;
  bit  noise = 1'b0;
  int  exp_rd_layer = 0;
  int  n_writes = 0;

  // Reference: Q8.8 multiply, floor shift, clamp.
  function automatic logic [DW-1:0] ref_ms(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[DW-1:0];
  endfunction

  function automatic void build_expected(input int n);
    logic [DW-1:0] delta[SZ];
    logic [DW-1:0] d;
    wr_t w;
    for (int l = n - 1; l >= 0; l--) begin
      w.layer = l;
      w.grad  = '0;
      for (int i = 0; i < SZ; i++) begin
        d = (l == n - 1) ? cost_a[l][i] : delta[i];
        w.grad[i*DW +: DW] = ref_ms(d, start_a[l][i]);
        delta[i] = ref_ms(d, toall_a[l][i]);
      end
      expq.push_back(w);
    end
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    int v;
    if ($urandom_range(0, 1) == 1) return DW'($urandom_range(0, 65535));
    v = int'($urandom_range(0, 2047)) - 1024;
    return v[DW-1:0];
  endfunction

  function automatic void fill_random();
    for (int l = 0; l < 16; l++)
      for (int i = 0; i < SZ; i++) begin
        cost_a[l][i]  = rnd_val();
        start_a[l][i] = rnd_val();
        toall_a[l][i] = rnd_val();
      end
  endfunction

  // Read responder: acks after a configurable delay, checks rd_layer order and stability.
  int rd_wait = 0;
  bit rd_active = 1'b0;
  logic [LB-1:0] rd_hold;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_ack = 1'b0;
      rd_active = 1'b0;
    end else if (rd_req) begin
      if (!rd_active) begin
        rd_active = 1'b1;
        rd_wait = (cfg_rd < 0) ? int'($urandom_range(0, 4)) : cfg_rd;
        rd_hold = rd_layer;
        chk("rd_layer_order", rd_layer, exp_rd_layer);
        exp_rd_layer--;
      end else begin
        chk("rd_layer_stable", rd_layer, rd_hold);
      end
      if (rd_wait == 0) begin
        rd_ack = 1'b1;
        for (int i = 0; i < SZ; i++) begin
          diff_cost[i*DW +: DW]   = cost_a[rd_layer][i];
          diff_start[i*DW +: DW]  = start_a[rd_layer][i];
          diff_to_all[i*DW +: DW] = toall_a[rd_layer][i];
        end
      end else begin
        rd_wait--;
        rd_ack = 1'b0;
        if (noise) begin
          diff_cost = {$urandom, $urandom};
          diff_start = {$urandom, $urandom};
          diff_to_all = {$urandom, $urandom};
        end
      end
    end else begin
      rd_active = 1'b0;
      rd_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        diff_cost = {$urandom, $urandom};
        diff_start = {$urandom, $urandom};
        diff_to_all = {$urandom, $urandom};
      end
    end
  end

  // Write sink: stalls, checks hold-stability, scores each accepted write.
  int wr_wait = 0;
  bit wr_active = 1'b0;
  logic [LB-1:0] wl_hold;
  logic [SZ*DW-1:0] wg_hold;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_ready = 1'b0;
      wr_active = 1'b0;
    end else if (wr_valid) begin
      if (!wr_active) begin
        wr_active = 1'b1;
        wr_wait = (cfg_wr < 0) ? int'($urandom_range(0, 4)) : cfg_wr;
        wl_hold = wr_layer;
        wg_hold = wr_grad;
      end else begin
        chk("wr_layer_hold", wr_layer, wl_hold);
        chk("wr_grad_hold", wr_grad, wg_hold);
      end
      if (wr_wait == 0) begin
        wr_ready = 1'b1;
        wr_active = 1'b0;
        n_writes++;
        wr_log.push_back('{layer: int'(wr_layer), grad: wr_grad});
        if (expq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("wr_layer", wr_layer, e.layer);
          chk("wr_grad", wr_grad, e.grad);
        end
      end else begin
        wr_wait--;
        wr_ready = 1'b0;
      end
    end else begin
      if (wr_active) chk("wr_valid_dropped", 0, 1);
      wr_active = 1'b0;
      wr_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic run_pass(input int nl, input int d, input int s, input bit chk_lat, input int spur);
    int n, t0;
    bit seen;
    n = (nl == 0) ? 1 : nl;
    cfg_rd = d;
    cfg_wr = s;
    expq.delete();
    wr_log.delete();
    build_expected(n);
    exp_rd_layer = n - 1;
    n_writes = 0;
    @(negedge clk);
    start = 1'b1;
    num_layers = nl[LB-1:0];
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    num_layers = LB'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (k == spur);
      if (k == spur) num_layers = 4'd7;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) begin
      if (chk_lat) chk("pass_latency", cyc - t0, n * (3 + d + s) + 1);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("write_count", n_writes, n);
      chk("expected_drained", expq.size(), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; num_layers = '0;
    rd_ack = 1'b0; wr_ready = 1'b0;
    diff_cost = '0; diff_start = '0; diff_to_all = '0;
    fill_random();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_layer", rd_layer, 0);
    chk("rst_wr_layer", wr_layer, 0);
    chk("rst_wr_grad", wr_grad, 0);
    rst_n = 1'b1;

    // Single layer, unit cost.
    for (int i = 0; i < SZ; i++) cost_a[0][i] = 16'h0100;
    start_a[0][0] = 16'h0200; start_a[0][1] = 16'h0080; start_a[0][2] = 16'hFF00;
    run_pass(1, 0, 0, 1, -1);
    chk("single_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("single_layer", wr_log[0].layer, 0);
      chk("single_grad", wr_log[0].grad, 48'hFF00_0080_0200);
    end

    // Three layers with chained delta.
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < SZ; i++) begin
        cost_a[l][i] = 16'h0200; toall_a[l][i] = 16'h0080; start_a[l][i] = 16'h0100;
      end
    run_pass(3, 0, 0, 1, -1);
    chk("chain_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("chain_l2", wr_log[0].layer, 2);
      chk("chain_g2", wr_log[0].grad, 48'h0200_0200_0200);
      chk("chain_l1", wr_log[1].layer, 1);
      chk("chain_g1", wr_log[1].grad, 48'h0100_0100_0100);
      chk("chain_l0", wr_log[2].layer, 0);
      chk("chain_g0", wr_log[2].grad, 48'h0080_0080_0080);
    end

    // Saturation both ways, with num_layers = 0 acting as one layer.
    cost_a[0][0] = 16'h7F00; start_a[0][0] = 16'h7F00;
    cost_a[0][1] = 16'h8000; start_a[0][1] = 16'h7F00;
    cost_a[0][2] = 16'h7F00; start_a[0][2] = 16'h8000;
    run_pass(0, 0, 0, 1, -1);
    if (wr_log.size() == 1) begin
      chk("sat_layer", wr_log[0].layer, 0);
      chk("sat_grad", wr_log[0].grad, 48'h8000_8000_7FFF);
    end

    // Backpressure on both ports.
    fill_random();
    run_pass(2, 4, 5, 1, -1);

    // Start pulse mid-pass is ignored.
    fill_random();
    run_pass(3, 0, 0, 1, 4);

    // Random passes with random delays and out-of-state noise.
    noise = 1'b1;
    for (int r = 0; r < 25; r++) begin
      fill_random();
      run_pass(int'($urandom_range(0, 7)), -1, -1, 0, -1);
    end
    noise = 1'b0;

    // Reset while layer 1 of three is waiting to be written.
    fill_random();
    cfg_rd = 0; cfg_wr = 4;
    expq.delete();
    build_expected(3);
    exp_rd_layer = 2;
    @(negedge clk);
    start = 1'b1; num_layers = 4'd3;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (wr_valid && wr_layer == 4'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reached_l1", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_valid", wr_valid, 0);
    chk("abort_rd_req", rd_req, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_grad", wr_grad, 0);
    chk("abort_wr_layer", wr_layer, 0);
    chk("abort_rd_layer", rd_layer, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_abort_idle", {busy, done}, 2'b00);
    end
    run_pass(3, 0, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
